// File: rtl/axis_switch_out_sched.sv
// Per-output-port round-robin packet scheduler for the AXI Stream switch.
// Define AXIS_SWITCH_SCHED_TIMEOUT_EN to add the stall timeout with forced release.
module axis_switch_out_sched #(
  parameter int N_IN        = 8,
  parameter int ID_W        = $clog2(N_IN),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] s_tvalid_i,
  input  logic [N_IN-1:0] s_tlast_i,
  output logic [N_IN-1:0] s_tready_o,
  output logic            m_tvalid_o,
  output logic            m_tlast_o,
  input  logic            m_tready_i,
  output logic [ID_W-1:0] sel_id_o,
  output logic            sel_vld_o,
  output logic [15:0]     pkt_cnt_o,
  output logic            timeout_o
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] win_idle;
  logic [ID_W-1:0] win_eop;
  logic            any_req;
  logic            beat;
  logic            eop;
  logic            force_rel;

  // First requester at or after base, wrapping modulo N_IN (works for any N_IN).
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_IN-1:0] req,
                                              input logic [ID_W-1:0] base);
    logic [ID_W-1:0] w;
    logic [N_IN-1:0] sh;
    logic            found;
    int              idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_IN; k++) begin
      idx = int'(base) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      sh = req >> idx;
      if (!found && sh[0]) begin
        w     = ID_W'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  always_comb begin
    m_tvalid_o = sel_vld_o & s_tvalid_i[sel_id_o];
    m_tlast_o  = sel_vld_o & s_tlast_i[sel_id_o];
    s_tready_o = '0;
    if (sel_vld_o && m_tready_i) s_tready_o = N_IN'(1) << sel_id_o;
  end

  assign beat     = m_tvalid_o & m_tready_i;
  assign eop      = beat & m_tlast_o;
  assign any_req  = |s_tvalid_i;
  assign ptr_nxt  = (sel_id_o == ID_W'(N_IN - 1)) ? '0 : sel_id_o + ID_W'(1);
  assign win_idle = rr_pick(s_tvalid_i, ptr);
  // Re-arbitration at end of packet already sees the rotated pointer.
  assign win_eop  = rr_pick(s_tvalid_i, ptr_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      sel_id_o  <= '0;
      sel_vld_o <= 1'b0;
      pkt_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sel_id_o  <= win_idle;
            sel_vld_o <= 1'b1;
            state     <= LOCK;
          end
        end
        LOCK: begin
          if (eop) begin
            pkt_cnt_o <= pkt_cnt_o + 16'd1;
            ptr       <= ptr_nxt;
            if (any_req) begin
              sel_id_o <= win_eop;
            end else begin
              sel_vld_o <= 1'b0;
              state     <= IDLE;
            end
          end else if (force_rel) begin
            ptr       <= ptr_nxt;
            sel_vld_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          sel_vld_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef AXIS_SWITCH_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] stall_cnt;

  // A beat in the terminal cycle wins over the timeout and clears the count.
  assign force_rel = (state == LOCK) && !beat && (stall_cnt == TO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= force_rel;
      if (state != LOCK || beat || force_rel) stall_cnt <= '0;
      else                                   stall_cnt <= stall_cnt + TO_W'(1);
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign force_rel          = 1'b0;
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: doc/axis_switch_out_sched.md
Name: axis_switch_out_sched

Overview:
- Per-output-port scheduler for the AXI Stream switch. Shares one output port between N_IN input streams.
- Grants ownership round-robin and holds it for a whole packet, released on the tlast beat.
- Drives the select for the external data mux and gates tvalid/tready between the winning input and the output.
- One instance per switch output port.

Parameters:
N_IN, 8, number of input streams competing for this output (>=2)
ID_W, $clog2(N_IN), width of the selected-input index
TIMEOUT_CYC, 1024, stall cycles inside a locked packet before forced release (used only with the optional feature)

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
s_tvalid_i  input  N_IN  per-input tvalid, also the request
s_tlast_i  input  N_IN  per-input tlast
s_tready_o  output  N_IN  per-input tready
m_tvalid_o  output  1  output-port tvalid
m_tlast_o  output  1  output-port tlast
m_tready_i  input  1  output-port tready
sel_id_o  output  ID_W  index of the owning input; drives the data mux
sel_vld_o  output  1  1 while an input owns the port
pkt_cnt_o  output  16  count of completed packets, wraps at 16 bits
timeout_o  output  1  one-cycle pulse on forced release; constant 0 without the feature

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset state: state=IDLE, pointer=0, sel_id_o=0, sel_vld_o=0, pkt_cnt_o=0, timeout_o=0, stall counter=0.
- Reset asserted mid-packet aborts the packet. One cycle after reset is sampled, m_tvalid_o and all s_tready_o are 0.
- The pointer holds the highest-priority index. Search order: pointer, pointer+1, ... N_IN-1, 0, ... pointer-1. Wrap is modulo N_IN, so non-power-of-2 N_IN is legal.
- States:
  - IDLE: sel_vld_o=0, m_tvalid_o=0, s_tready_o=0.
    - If any s_tvalid_i is set, register winner w into sel_id_o, set sel_vld_o=1, go to LOCK.
    - Arbitration latency is 1 cycle: the first beat can transfer in the cycle after the request is first seen.
  - LOCK (combinational pass-through, no added latency):
    - m_tvalid_o = s_tvalid_i[sel_id_o].
    - m_tlast_o = s_tlast_i[sel_id_o].
    - s_tready_o[i] = m_tready_i & (i==sel_id_o); all others 0.
- A beat is m_tvalid_o & m_tready_i. Ownership never changes before a beat with tlast. Requests from other inputs are ignored until then.
- End of packet (beat with tlast):
  - pkt_cnt_o increments by 1 (0xFFFF wraps to 0x0000).
  - pointer becomes (sel_id_o+1) mod N_IN.
  - In the same cycle, re-arbitrate on the current s_tvalid_i with the new pointer:
    - If any request is present, stay in LOCK with the new sel_id_o (zero-bubble back-to-back packets).
    - Otherwise go to IDLE.
  - The previous owner has lowest priority. It wins again only if it is the sole requester.
- A single-beat packet (tlast on the first beat) is legal: grant, transfer and release all happen in one LOCK cycle.
- Input tvalid dropping mid-packet keeps ownership. m_tvalid_o follows it to 0.
- m_tready_i low holds all s_tready_o low. State is unchanged.
- An output port sequence is never interleaved between inputs.

Optional Feature:
- Macro: AXIS_SWITCH_SCHED_TIMEOUT_EN.
- Defined:
  - A stall counter, clog2(TIMEOUT_CYC+1) bits wide, counts LOCK cycles with no beat. It clears on any beat and in IDLE.
  - When it reaches TIMEOUT_CYC, the next edge forces release: timeout_o=1 for one cycle, pointer=(sel_id_o+1) mod N_IN, state=IDLE, sel_vld_o=0.
  - pkt_cnt_o is not incremented by a forced release.
  - The abandoned input loses the remainder of its packet; upstream handles recovery.
- Undefined: no counter logic. timeout_o is tied to 0. A locked packet may hold the port indefinitely.

Test Plan (N_IN=4, TIMEOUT_CYC=16 where the feature is on):
- Reset, then s_tvalid_i=4'b1010 held, 3-beat packets, m_tready_i=1 -> grants in order 1,3,1,3. No idle cycle between packets. pkt_cnt_o steps 1,2,3,4.
- Input 2 mid-packet (beat 2 of 4) while input 0 raises tvalid -> sel_id_o stays 2 until its tlast beat, then switches to 0 in the same cycle. Input 0 sees s_tready_o[0]=0 throughout.
- m_tready_i toggled 1,0,0,1 during a packet from input 3 -> s_tready_o[3] mirrors m_tready_i and only 4'b1000 is ever set. No ownership change.
- Single-beat packets on all four inputs, tlast=1 constant -> one beat per cycle in grant order 0,1,2,3,0. pkt_cnt_o counts from 0xFFFE and wraps to 0x0000.
- reset asserted during beat 2 of a packet from input 1 -> next cycle sel_vld_o=0, s_tready_o=0, pkt_cnt_o=0. A later request from inputs 1 and 2 grants input 1 (pointer=0).
- Feature on: input 2 locked, tvalid low for 16 cycles -> timeout_o pulses once, sel_vld_o=0, pkt_cnt_o unchanged, next grant favours input 3. Feature off: port stays locked with timeout_o=0.
